vroom_system_ram_arbiter: RTL and testbench

- Two-requester round-robin arbiter sharing the single-port 8192x32 on-chip RAM (byte-enabled, 1-cycle read latency, unregistered output) between two Avalon-MM style masters.
- Sits between the two masters (m0, m1) and the RAM slave port, and drives chipselect/write/address/byteenable/writedata.
- Optional post-reset zero-fill sequencer walks every RAM word before any master access is accepted.

---
 rtl/vroom_system_ram_arbiter_if.sv | 32 +++
 rtl/vroom_system_ram_arbiter.sv | 132 +++++++++++++
 tb/tb_vroom_system_ram_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vroom_system_ram_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : vroom_system_ram_arbiter_if
//  Purpose  : Avalon-MM style word-addressed port carrying one master's
//             request/response signals toward the shared RAM arbiter.
//  Revision : 1.0  initial release
// ============================================================================
interface vroom_system_ram_arbiter_if #(
    parameter int ADDR_W = 13
);
    logic [ADDR_W-1:0] address;
    logic [3:0]        byteenable;
    logic              read;
    logic              write;
    logic [31:0]       writedata;
    logic              waitrequest;
    logic [31:0]       readdata;
    logic              readdatavalid;

    // Requester side: issues commands, receives stall and read data
    modport master (
        output address, byteenable, read, write, writedata,
        input  waitrequest, readdata, readdatavalid
    );

    // Arbiter side: accepts commands, returns stall and read data
    modport slave (
        input  address, byteenable, read, write, writedata,
        output waitrequest, readdata, readdatavalid
    );
endinterface
`default_nettype wire

// File: rtl/vroom_system_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : vroom_system_ram_arbiter
//  Purpose  : Round-robin arbiter sharing a single-port byte-enabled RAM
//             between two Avalon-MM masters, with an optional post-reset
//             zero-fill pass over every RAM word.
//  Revision : 1.0  initial release
// ============================================================================
module vroom_system_ram_arbiter #(
    parameter int ADDR_W         = 13,
    parameter int DEPTH          = 8192,
    parameter int CLEAR_ON_RESET = 1
) (
    input  wire logic                  clk,
    input  wire logic                  reset,
    vroom_system_ram_arbiter_if.slave  m0,
    vroom_system_ram_arbiter_if.slave  m1,
    output logic                       ram_chipselect,
    output logic                       ram_write,
    output logic [ADDR_W-1:0]          ram_address,
    output logic [3:0]                 ram_byteenable,
    output logic [31:0]                ram_writedata,
    input  wire logic [31:0]           ram_readdata,
    output logic                       clear_done
);

    localparam logic [1:0]        c_ST_INIT  = 2'd0;
    localparam logic [1:0]        c_ST_CLEAR = 2'd1;
    localparam logic [1:0]        c_ST_ARB   = 2'd2;
    localparam logic [ADDR_W-1:0] c_LAST_ADDR     = ADDR_W'(DEPTH - 1);
    localparam logic              c_DONE_AT_RESET = (CLEAR_ON_RESET == 0);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] clear_addr_q, clear_addr_d;
    logic              last_grant_q, last_grant_d;
    logic              rd_pend_q, rd_pend_d;
    logic              rd_owner_q, rd_owner_d;
    logic              clear_done_q, clear_done_d;

    logic              w_arb;
    logic              w_req0, w_req1;
    logic              w_gnt0, w_gnt1;

    // State register; reset always returns to the idle cycle before clear/arb
    always_ff @(posedge clk) begin
        if (reset) state_q <= c_ST_INIT;
        else       state_q <= state_d;
    end

    // Next-state: optional clear pass, then arbitration forever
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_ST_INIT:  state_d = (CLEAR_ON_RESET != 0) ? c_ST_CLEAR : c_ST_ARB;
            c_ST_CLEAR: if (clear_addr_q == c_LAST_ADDR) state_d = c_ST_ARB;
            c_ST_ARB:   state_d = c_ST_ARB;
            default:    state_d = c_ST_INIT;
        endcase
    end

    // Outputs: clear writes, same-cycle grant and RAM mux; reset blanks all
    always_comb begin
        w_arb  = (state_q == c_ST_ARB) && !reset;
        w_req0 = m0.read || m0.write;
        w_req1 = m1.read || m1.write;
        // On conflict the master that was not served last wins
        w_gnt0 = w_arb && w_req0 && (!w_req1 || last_grant_q);
        w_gnt1 = w_arb && w_req1 && (!w_req0 || !last_grant_q);

        m0.waitrequest = !w_gnt0;
        m1.waitrequest = !w_gnt1;

        ram_chipselect = 1'b0;
        ram_write      = 1'b0;
        ram_address    = m0.address;
        ram_byteenable = m0.byteenable;
        ram_writedata  = m0.writedata;

        if ((state_q == c_ST_CLEAR) && !reset) begin
            ram_chipselect = 1'b1;
            ram_write      = 1'b1;
            ram_address    = clear_addr_q;
            ram_byteenable = 4'hF;
            ram_writedata  = 32'h0;
        end else if (w_gnt0) begin
            ram_chipselect = 1'b1;
            ram_write      = m0.write;
        end else if (w_gnt1) begin
            ram_chipselect = 1'b1;
            ram_write      = m1.write;
            ram_address    = m1.address;
            ram_byteenable = m1.byteenable;
            ram_writedata  = m1.writedata;
        end

        // A read+write request is a write; only a pure read expects data back
        rd_pend_d    = (w_gnt0 && m0.read && !m0.write) ||
                       (w_gnt1 && m1.read && !m1.write);
        rd_owner_d   = (w_gnt0 || w_gnt1) ? w_gnt1 : rd_owner_q;
        last_grant_d = (w_gnt0 || w_gnt1) ? w_gnt1 : last_grant_q;
        clear_addr_d = (state_q == c_ST_CLEAR) ? clear_addr_q + 1'b1 : clear_addr_q;
        clear_done_d = clear_done_q ||
                       ((state_q == c_ST_CLEAR) && (clear_addr_q == c_LAST_ADDR));

        // RAM q is shared; the valid strobe steers it, and reset kills it
        m0.readdata      = ram_readdata;
        m1.readdata      = ram_readdata;
        m0.readdatavalid = rd_pend_q && !rd_owner_q && !reset;
        m1.readdatavalid = rd_pend_q &&  rd_owner_q && !reset;

        clear_done = reset ? c_DONE_AT_RESET : clear_done_q;
    end

    // Datapath registers: clear pointer, fairness history, read tracking
    always_ff @(posedge clk) begin
        if (reset) begin
            clear_addr_q <= '0;
            last_grant_q <= 1'b1;
            rd_pend_q    <= 1'b0;
            rd_owner_q   <= 1'b0;
            clear_done_q <= c_DONE_AT_RESET;
        end else begin
            clear_addr_q <= clear_addr_d;
            last_grant_q <= last_grant_d;
            rd_pend_q    <= rd_pend_d;
            rd_owner_q   <= rd_owner_d;
            clear_done_q <= clear_done_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vroom_system_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vroom_system_ram_arbiter
//  Purpose  : Self-checking bench for the two-master RAM arbiter, with a
//             behavioural RAM and a reference model of grants and data.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vroom_system_ram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        ram_chipselect, ram_write, clear_done;
    logic [12:0] ram_address;
    logic [3:0]  ram_byteenable;
    logic [31:0] ram_writedata, ram_q;

    vroom_system_ram_arbiter_if #(.ADDR_W(13)) m0_if ();
    vroom_system_ram_arbiter_if #(.ADDR_W(13)) m1_if ();

    vroom_system_ram_arbiter #(.ADDR_W(13), .DEPTH(8192), .CLEAR_ON_RESET(1)) dut (
        .clk            (clk),
        .reset          (reset),
        .m0             (m0_if),
        .m1             (m1_if),
        .ram_chipselect (ram_chipselect),
        .ram_write      (ram_write),
        .ram_address    (ram_address),
        .ram_byteenable (ram_byteenable),
        .ram_writedata  (ram_writedata),
        .ram_readdata   (ram_q),
        .clear_done     (clear_done)
    );

    always #5 clk = ~clk;

    // Behavioural single-port RAM with registered q, plus a back-door fill
    logic        tb_fill = 1'b0;
    logic [12:0] fill_addr = '0;
    logic [31:0] fill_data = '0;
    logic [31:0] mem [0:8191];
    always @(posedge clk) begin
        if (tb_fill) mem[fill_addr] <= fill_data;
        else if (ram_chipselect) begin
            if (ram_write) begin
                for (int b = 0; b < 4; b++)
                    if (ram_byteenable[b]) mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
            end else ram_q <= mem[ram_address];
        end
    end

    // Reference model state
    logic [31:0] ref_mem [0:8191];
    int          exp_last;
    logic [1:0]  pend_v;
    logic [31:0] pend_d;
    int          wcnt [2];
    int          last_g;
    logic        held [2];
    int          n_assert = 0;
    int          n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8192; i++) ref_mem[i] = 32'h0;
        exp_last = 1;
        pend_v   = 2'b00;
        wcnt[0]  = 0;
        wcnt[1]  = 0;
    endtask

    // Wait out the zero-fill with m0 requesting; checks every clear cycle
    task automatic clear_and_wait();
        int n   = 0;
        int bad = 0;
        while (m0_if.waitrequest === 1'b1 && n < 9000) begin
            if (n == 0) begin
                if (ram_chipselect !== 1'b0) bad++;
            end else if (ram_chipselect !== 1'b1 || ram_write !== 1'b1 ||
                         ram_byteenable !== 4'hF || ram_writedata !== 32'h0 ||
                         ram_address !== 13'(n - 1)) bad++;
            if (clear_done !== 1'b0 || m1_if.waitrequest !== 1'b1) bad++;
            @(posedge clk);
            #2;
            n++;
        end
        chk("clear_wait_cycles", n, 8193);
        chk("clear_bad_cycles", bad, 0);
        chk("clear_done_high", clear_done, 1'b1);
        model_reset();
    endtask

    // One arbitration cycle: check returns, grant and RAM drive vs the model
    task automatic arb_step();
        logic [1:0]  rq, wr;
        logic [12:0] ad [2];
        logic [3:0]  bm [2];
        logic [31:0] wd [2];
        int g;
        #1;
        rq = {m1_if.read | m1_if.write, m0_if.read | m0_if.write};
        wr = {m1_if.write, m0_if.write};
        ad[0] = m0_if.address;    ad[1] = m1_if.address;
        bm[0] = m0_if.byteenable; bm[1] = m1_if.byteenable;
        wd[0] = m0_if.writedata;  wd[1] = m1_if.writedata;
        chk("rdv0", m0_if.readdatavalid, pend_v[0]);
        chk("rdv1", m1_if.readdatavalid, pend_v[1]);
        if (pend_v[0]) chk("rdata0", m0_if.readdata, pend_d);
        if (pend_v[1]) chk("rdata1", m1_if.readdata, pend_d);
        pend_v = 2'b00;
        g = -1;
        if (rq == 2'b11) g = 1 - exp_last;
        else if (rq[0])  g = 0;
        else if (rq[1])  g = 1;
        chk("wait0", m0_if.waitrequest, g != 0);
        chk("wait1", m1_if.waitrequest, g != 1);
        chk("chipselect", ram_chipselect, g >= 0);
        if (g >= 0) begin
            chk("ram_addr", ram_address, ad[g]);
            chk("ram_write", ram_write, wr[g]);
            if (wr[g]) begin
                chk("ram_be", ram_byteenable, bm[g]);
                chk("ram_wdata", ram_writedata, wd[g]);
                for (int b = 0; b < 4; b++)
                    if (bm[g][b]) ref_mem[ad[g]][8*b +: 8] = wd[g][8*b +: 8];
            end else begin
                pend_v[g] = 1'b1;
                pend_d    = ref_mem[ad[g]];
            end
            exp_last = g;
        end
        for (int m = 0; m < 2; m++) begin
            if (rq[m] && g != m) begin
                wcnt[m]++;
                chk("max_wait", wcnt[m] <= 1, 1'b1);
            end else wcnt[m] = 0;
        end
        last_g = g;
    endtask

    task automatic rnd(output logic rd, output logic wr, output logic [12:0] a,
                       output logic [3:0] be, output logic [31:0] d);
        int k;
        k  = $urandom_range(0, 9);
        rd = (k <= 3) || (k == 7);
        wr = (k >= 4) && (k <= 7);
        a  = 13'($urandom_range(0, 7));
        be = 4'($urandom);
        d  = $urandom;
    endtask

    task automatic idle_all();
        m0_if.read = 1'b0; m0_if.write = 1'b0;
        m1_if.read = 1'b0; m1_if.write = 1'b0;
    endtask

    initial begin
        int          k;
        logic        r, w;
        logic [12:0] a;
        logic [3:0]  be;
        logic [31:0] d;

        reset = 1'b1;
        idle_all();
        m0_if.address = '0; m0_if.byteenable = '0; m0_if.writedata = '0;
        m1_if.address = '0; m1_if.byteenable = '0; m1_if.writedata = '0;
        model_reset();

        // Reset held: preload garbage that the clear must wipe
        for (int i = 0; i < 24; i++) begin
            next();
            tb_fill   = 1'b1;
            fill_addr = (i < 6) ? 13'(i + 1) : 13'($urandom_range(0, 63));
            if (i == 6) fill_addr = 13'h10;
            if (i == 7) fill_addr = 13'h20;
            fill_data = $urandom | 32'h1;
        end
        #1;
        chk("rst_wait0", m0_if.waitrequest, 1'b1);
        chk("rst_wait1", m1_if.waitrequest, 1'b1);
        chk("rst_rdv0", m0_if.readdatavalid, 1'b0);
        chk("rst_cs", ram_chipselect, 1'b0);
        chk("rst_clear_done", clear_done, 1'b0);

        // Clear pass with m0 reading 0x0005 throughout, then its data is 0
        next();
        tb_fill = 1'b0;
        reset   = 1'b0;
        m0_if.read = 1'b1; m0_if.address = 13'h0005;
        #1;
        clear_and_wait();
        arb_step();
        next();
        idle_all();
        arb_step();
        chk("A_rdv", m0_if.readdatavalid, 1'b1);
        chk("A_rdata", m0_if.readdata, 32'h0);

        // Full write, byte-lane write, read back merged word
        next();
        m0_if.write = 1'b1; m0_if.address = 13'h10; m0_if.byteenable = 4'hF; m0_if.writedata = 32'hDEADBEEF;
        arb_step();
        next();
        m0_if.byteenable = 4'h1; m0_if.writedata = 32'h000000AA;
        arb_step();
        next();
        m0_if.write = 1'b0; m0_if.read = 1'b1;
        arb_step();
        chk("B_rdv_same_cycle", m0_if.readdatavalid, 1'b0);
        next();
        idle_all();
        arb_step();
        chk("B_rdv", m0_if.readdatavalid, 1'b1);
        chk("B_rdata", m0_if.readdata, 32'hDEADBEAA);

        // Seed 0x1 / 0x2 via a write conflict, then sustained dual reads
        next();
        m0_if.write = 1'b1; m0_if.address = 13'h1; m0_if.byteenable = 4'hF; m0_if.writedata = 32'h11111111;
        m1_if.write = 1'b1; m1_if.address = 13'h2; m1_if.byteenable = 4'hF; m1_if.writedata = 32'h22222222;
        arb_step();
        next();
        m1_if.write = 1'b0;
        arb_step();
        next();
        m0_if.write = 1'b0; m0_if.read = 1'b1;
        m1_if.read  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            arb_step();
            next();
        end
        idle_all();
        arb_step();

        // Reset at clear_addr 100 restarts the clear from 0
        next();
        reset = 1'b1;
        m0_if.write = 1'b1; m0_if.read = 1'b0; m0_if.address = 13'h20;
        m0_if.byteenable = 4'hF; m0_if.writedata = 32'hC0FFEE20;
        m1_if.read = 1'b1; m1_if.address = 13'h20;
        #1;
        chk("rst2_clear_done", clear_done, 1'b0);
        chk("rst2_cs", ram_chipselect, 1'b0);
        next();
        reset = 1'b0;
        #1;
        k = 0;
        while (!(ram_chipselect === 1'b1 && ram_address === 13'd100) && k < 300) begin
            next();
            #1;
            k++;
        end
        chk("clear_reach_100", k, 101);
        reset = 1'b1;
        #1;
        chk("midclear_rst_cs", ram_chipselect, 1'b0);
        chk("midclear_rst_done", clear_done, 1'b0);
        next();
        reset = 1'b0;
        #1;
        clear_and_wait();

        // First conflict after reset: m0 write wins, m1 read sees new data
        arb_step();
        chk("C_wait0", m0_if.waitrequest, 1'b0);
        chk("C_wait1", m1_if.waitrequest, 1'b1);
        next();
        m0_if.write = 1'b0;
        arb_step();
        next();
        idle_all();
        arb_step();
        chk("C_rdv1", m1_if.readdatavalid, 1'b1);
        chk("C_rdata1", m1_if.readdata, 32'hC0FFEE20);

        // Randomized traffic, inputs held stable while stalled
        held[0] = 1'b0;
        held[1] = 1'b0;
        for (int i = 0; i < 400; i++) begin
            next();
            if (!held[0]) begin
                rnd(r, w, a, be, d);
                m0_if.read = r; m0_if.write = w; m0_if.address = a; m0_if.byteenable = be; m0_if.writedata = d;
            end
            if (!held[1]) begin
                rnd(r, w, a, be, d);
                m1_if.read = r; m1_if.write = w; m1_if.address = a; m1_if.byteenable = be; m1_if.writedata = d;
            end
            arb_step();
            held[0] = (m0_if.read | m0_if.write) && (last_g != 0);
            held[1] = (m1_if.read | m1_if.write) && (last_g != 1);
        end
        next();
        idle_all();
        arb_step();

        // Reset while a read is in flight: no valid may appear
        next();
        m0_if.read = 1'b1; m0_if.write = 1'b0; m0_if.address = 13'h3;
        arb_step();
        next();
        idle_all();
        reset = 1'b1;
        #1;
        chk("flight_rst_rdv0", m0_if.readdatavalid, 1'b0);
        next();
        reset = 1'b0;
        #1;
        chk("flight_after_rdv0", m0_if.readdatavalid, 1'b0);
        next();
        #1;
        chk("flight_after2_rdv0", m0_if.readdatavalid, 1'b0);
        chk("flight_after2_rdv1", m1_if.readdatavalid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
